// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and pointer bus between the FIFO pointer controller and its
// neighbours: producer/consumer requests, comparator ready/valid, memory
// strobes and the wrap-tagged pointers.
interface fifo_ptr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  i_valid_s;    // producer write request
    logic                  i_ready_m;    // consumer read request
    logic                  i_ready_s;    // comparator: FIFO not full
    logic                  i_valid_m;    // comparator: FIFO not empty
    logic                  o_wr_en;      // memory write strobe
    logic                  o_rd_en;      // memory read strobe
    logic [ADDR_WIDTH:0]   o_wr_addr;    // wrap-tagged write pointer
    logic [ADDR_WIDTH:0]   o_rd_addr;    // wrap-tagged read pointer
    logic [ADDR_WIDTH-1:0] o_mem_waddr;  // memory write address
    logic [ADDR_WIDTH-1:0] o_mem_raddr;  // memory read address

    // Pointer controller side
    modport slave (
        input  i_valid_s, i_ready_m, i_ready_s, i_valid_m,
        output o_wr_en, o_rd_en, o_wr_addr, o_rd_addr, o_mem_waddr, o_mem_raddr
    );

    // Environment side (producer, consumer, comparator, memory)
    modport master (
        output i_valid_s, i_ready_m, i_ready_s, i_valid_m,
        input  o_wr_en, o_rd_en, o_wr_addr, o_rd_addr, o_mem_waddr, o_mem_raddr
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointer controller for the synchronous FIFO. Qualifies producer
// writes and consumer reads against the comparator's ready/valid, owns the
// (ADDR_WIDTH+1)-bit wrap-tagged pointers and keeps sticky overflow/underflow
// flags for requests that arrive while full/empty.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif

module fifo_ptr_ctrl #(
    parameter int FIFO_DEPTH = `FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_err_clr,
    fifo_ptr_ctrl_if.slave    bus,
    output logic              o_overflow,
    output logic              o_underflow
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_en, rd_en;
    logic                ovf_set, unf_set;

    // Handshake qualification; strobes are forced low while reset is held so
    // the memory sees no spurious access during an asynchronous reset.
    always_comb begin
        wr_en   = rst_n & bus.i_valid_s & bus.i_ready_s & ~i_flush;
        rd_en   = rst_n & bus.i_ready_m & bus.i_valid_m & ~i_flush;
        ovf_set = bus.i_valid_s & ~bus.i_ready_s & ~i_flush;
        unf_set = bus.i_ready_m & ~bus.i_valid_m & ~i_flush;
    end

    // Next-state pointers: flush clears both, otherwise each advances on its
    // own strobe; natural modulo-2^(ADDR_WIDTH+1) wrap toggles the tag bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Next-state sticky errors: a set in this cycle beats a clear request.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (ovf_set)        overflow_d = 1'b1;
        else if (i_err_clr) overflow_d = 1'b0;
        if (unf_set)        underflow_d = 1'b1;
        else if (i_err_clr) underflow_d = 1'b0;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Outputs: pointers straight from registers, so the comparator's
    // ready/valid never loop back combinationally into the strobes.
    assign bus.o_wr_en     = wr_en;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_wr_addr   = wr_ptr_q;
    assign bus.o_rd_addr   = rd_ptr_q;
    assign bus.o_mem_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign bus.o_mem_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign o_overflow      = overflow_q;
    assign o_underflow     = underflow_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl (depth 16). The flag comparator is
// modelled from the pointer outputs; all expected values are hand-computed.
module tb_fifo_ptr_ctrl;
    logic clk;
    logic rst_n;
    logic flush;
    logic err_clr;
    logic ovf;
    logic unf;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt;
    int rd_cnt;
    logic wr_seen;
    logic rd_seen;
    logic [4:0] occ;

    fifo_ptr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    fifo_ptr_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_err_clr   (err_clr),
        .bus         (bus),
        .o_overflow  (ovf),
        .o_underflow (unf)
    );

    // Comparator model: full when pointers differ by the depth, empty when equal
    assign occ           = bus.o_wr_addr - bus.o_rd_addr;
    assign bus.i_ready_s = (occ != 5'd16);
    assign bus.i_valid_m = (bus.o_wr_addr != bus.o_rd_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %0d", tag, got);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive requests, capture the combinational strobes, then
    // advance past the edge so registered outputs can be sampled.
    task automatic step(input logic vs, input logic rm, input logic fl, input logic ec);
        bus.i_valid_s = vs;
        bus.i_ready_m = rm;
        flush         = fl;
        err_clr       = ec;
        #1;
        wr_seen = bus.o_wr_en;
        rd_seen = bus.o_rd_en;
        if (wr_seen === 1'b1) wr_cnt++;
        if (rd_seen === 1'b1) rd_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; err_clr = 1'b0;
        bus.i_valid_s = 1'b1;
        bus.i_ready_m = 1'b1;
        wr_cnt = 0; rd_cnt = 0;

        // T1: reset with requests high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   bus.o_wr_en,   0);
        chk("rst_rd_en",   bus.o_rd_en,   0);
        chk("rst_wr_addr", bus.o_wr_addr, 0);
        chk("rst_rd_addr", bus.o_rd_addr, 0);
        chk("rst_ovf",     ovf,           0);
        chk("rst_unf",     unf,           0);
        bus.i_valid_s = 1'b0;
        bus.i_ready_m = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.i_ready_m = 1'b1;
        #1;
        chk("post_rst_rd_en_empty", bus.o_rd_en, 0);
        chk("post_rst_wr_en_idle",  bus.o_wr_en, 0);
        bus.i_ready_m = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_wr_addr", bus.o_wr_addr, 0);
        chk("post_rst_rd_addr", bus.o_rd_addr, 0);

        // T2: fill
        wr_cnt = 0;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
        chk("fill_wr_cnt",    wr_cnt,          16);
        chk("fill_wr_addr",   bus.o_wr_addr,   5'b10000);
        chk("fill_mem_waddr", bus.o_mem_waddr, 0);
        chk("fill_ovf",       ovf,             0);
        step(1, 0, 0, 0);
        chk("ovf_wr_en",   wr_seen,       0);
        chk("ovf_wr_addr", bus.o_wr_addr, 5'b10000);
        chk("ovf_set",     ovf,           1);

        // T3: drain, underflow, error clear
        rd_cnt = 0;
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        chk("drain_rd_cnt",    rd_cnt,          16);
        chk("drain_rd_addr",   bus.o_rd_addr,   5'b10000);
        chk("drain_mem_raddr", bus.o_mem_raddr, 0);
        step(0, 1, 0, 0);
        chk("unf_rd_en",   rd_seen,       0);
        chk("unf_rd_addr", bus.o_rd_addr, 5'b10000);
        chk("unf_set",     unf,           1);
        chk("ovf_sticky",  ovf,           1);
        step(0, 0, 0, 1);
        chk("clr_ovf", ovf, 0);
        chk("clr_unf", unf, 0);

        // T4: flush to origin, one write, then 40 cycles streaming across the wrap
        step(0, 0, 1, 0);
        chk("flush0_wr_addr", bus.o_wr_addr, 0);
        step(1, 0, 0, 0);
        wr_cnt = 0; rd_cnt = 0;
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
        chk("stream_wr_cnt", wr_cnt,        40);
        chk("stream_rd_cnt", rd_cnt,        40);
        chk("stream_wr",     bus.o_wr_addr, 9);
        chk("stream_rd",     bus.o_rd_addr, 8);
        chk("stream_ovf",    ovf,           0);
        chk("stream_unf",    unf,           0);

        // T5: reach full (wr 24, rd 8) then write+read together
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
        chk("full_wr_addr", bus.o_wr_addr, 24);
        step(1, 1, 0, 0);
        chk("fullrw_wr_en", wr_seen,       0);
        chk("fullrw_rd_en", rd_seen,       1);
        chk("fullrw_wr",    bus.o_wr_addr, 24);
        chk("fullrw_rd",    bus.o_rd_addr, 9);
        chk("fullrw_ovf",   ovf,           1);
        step(1, 0, 0, 0);
        chk("retry_wr_en", wr_seen,       1);
        chk("retry_wr",    bus.o_wr_addr, 25);

        // Empty with write+read: write proceeds, read blocked, no bypass
        step(0, 0, 1, 0);
        chk("flush_keeps_ovf", ovf, 1);
        step(1, 1, 0, 0);
        chk("emptyrw_wr_en", wr_seen,       1);
        chk("emptyrw_rd_en", rd_seen,       0);
        chk("emptyrw_wr",    bus.o_wr_addr, 1);
        chk("emptyrw_rd",    bus.o_rd_addr, 0);
        chk("emptyrw_unf",   unf,           1);
        step(0, 1, 0, 0);
        chk("late_rd_en", rd_seen,       1);
        chk("late_rd",    bus.o_rd_addr, 1);
        // Empty read with clear: underflow set wins, overflow clears
        step(0, 1, 0, 1);
        chk("setwins_unf", unf, 1);
        chk("clr_only_ovf", ovf, 0);

        // T6: 5 writes then flush with requests high
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("pre_flush_wr", bus.o_wr_addr, 6);
        step(1, 1, 1, 0);
        chk("flush_wr_en", wr_seen,       0);
        chk("flush_rd_en", rd_seen,       0);
        chk("flush_wr",    bus.o_wr_addr, 0);
        chk("flush_rd",    bus.o_rd_addr, 0);
        chk("flush_unf",   unf,           1);
        chk("flush_ovf",   ovf,           0);

        // Async reset pulse mid-cycle
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("pre_arst_wr", bus.o_wr_addr, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr",    bus.o_wr_addr, 0);
        chk("arst_unf",   unf,           0);
        chk("arst_wr_en", bus.o_wr_en,   0);
        @(posedge clk); #1;
        bus.i_valid_s = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        chk("after_arst_wr", bus.o_wr_addr, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
